// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rst_seq.sv
// Reset release sequencer: all RN lines assert asynchronously on RST and release
// one by one, GAP clocks apart, after a SYNC_STAGES-deep deassertion synchroniser.
module gf180mcu_fd_sc_mcu9t5v0__rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int N_OUT       = 4,
  parameter int GAP         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SWRST,
  output logic [N_OUT-1:0] RN,
  output logic             DONE,
  input  logic             VDD,
  input  logic             VSS
);

  localparam int CW = $clog2(GAP + 1);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_OUT - 1);

  typedef enum logic [1:0] {HOLD, SEQ, RUN} state_t;

  state_t                 state_reg, state_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [N_OUT-1:0]       rn_reg, rn_next;
  logic                   done_reg, done_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_rise;
  logic                   unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= 1'b1;
        end
      end else begin : g_next
        always_ff @(posedge CLK or posedge RST) begin
          if (RST) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // rst_sync (last stage) is rising on this edge; leaving HOLD on the same edge
  // makes RN[0] release exactly GAP edges later.
  assign sync_rise = sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= HOLD;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      rn_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      rn_reg    <= rn_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    rn_next    = rn_reg;
    done_next  = done_reg;
    case (state_reg)
      HOLD: begin
        if (sync_rise) begin
          state_next = SEQ;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end
      SEQ, RUN: begin
        if (SWRST) begin
          // Counter is parked at 0 for as long as the request is held.
          state_next = SEQ;
          idx_next   = '0;
          cnt_next   = '0;
          rn_next    = '0;
          done_next  = 1'b0;
        end else if (state_reg == SEQ) begin
          if (cnt_reg == CNT_LAST) begin
            rn_next[idx_reg] = 1'b1;
            cnt_next         = '0;
            if (idx_reg == IDX_LAST) begin
              state_next = RUN;
              done_next  = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = HOLD;
    endcase
  end

  assign RN   = rn_reg;
  assign DONE = done_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rst_seq.sv
// Scoreboard bench for the reset release sequencer: expected {DONE,RN} per edge is
// derived from the release timeline and queued when stimulus is applied.
module tb_gf180mcu_fd_sc_mcu9t5v0__rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swrst = 1'b0;
  logic       rst_b = 1'b1;
  logic       swrst_b = 1'b0;
  logic       vdd = 1'b1;
  logic       vss = 1'b0;
  logic [3:0] rn0, rn1;
  logic [0:0] rn2;
  logic       done0, done1, done2;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__rst_seq #(.SYNC_STAGES(2), .N_OUT(4), .GAP(8)) dut0 (
    .CLK(clk), .RST(rst), .SWRST(swrst), .RN(rn0), .DONE(done0), .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu9t5v0__rst_seq #(.SYNC_STAGES(2), .N_OUT(4), .GAP(1)) dut1 (
    .CLK(clk), .RST(rst_b), .SWRST(swrst_b), .RN(rn1), .DONE(done1), .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu9t5v0__rst_seq #(.SYNC_STAGES(3), .N_OUT(1), .GAP(3)) dut2 (
    .CLK(clk), .RST(rst_b), .SWRST(swrst_b), .RN(rn2), .DONE(done2), .VDD(vdd), .VSS(vss));

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {done,rn}=%b required %b", tag, got, exp);
    end else begin
      $display("ok   %s: {done,rn}=%b", tag, got);
    end
  endtask

  function automatic logic [4:0] observe(input int which);
    case (which)
      0:       return {done0, rn0};
      1:       return {done1, rn1};
      default: return {done2, 3'b000, rn2};
    endcase
  endfunction

  // Line k is released on edge sync + (k+1)*gap; DONE when every line is out.
  function automatic logic [4:0] exp_vec(input int e, input int sync, input int gap, input int nout);
    logic [4:0] v = '0;
    int rel = 0;
    for (int k = 0; k < nout; k++) begin
      if (sync + (k + 1) * gap <= e) begin
        v[k] = 1'b1;
        rel++;
      end
    end
    v[4] = (rel == nout);
    return v;
  endfunction

  task automatic push_seq(input int n, input int sync, input int gap, input int nout);
    for (int e = 1; e <= n; e++) sb.push_back(exp_vec(e, sync, gap, nout));
  endtask

  task automatic push_const(input int n, input logic [4:0] v);
    for (int e = 1; e <= n; e++) sb.push_back(v);
  endtask

  task automatic run_edges(input int which, input int n, input string tag);
    logic [4:0] exp;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s e%0d: scoreboard empty, got %b required an entry", tag, i, observe(which));
      end else begin
        exp = sb.pop_front();
        check_val($sformatf("%s e%0d", tag, i), observe(which), exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. power-up in reset, then release between edges
    repeat (3) @(posedge clk);
    #1;
    check_val("por dut0", observe(0), 5'b00000);
    check_val("por dut1", observe(1), 5'b00000);
    check_val("por dut2", observe(2), 5'b00000);
    @(negedge clk) rst = 1'b0;
    push_seq(36, 2, 8, 4);
    run_edges(0, 36, "s1");

    // 2. sub-period RST pulse in RUN: immediate clear, no edge involved
    #2 rst = 1'b1;
    #1 check_val("s2 async clear", observe(0), 5'b00000);
    #3 rst = 1'b0;
    push_seq(18, 2, 8, 4);
    run_edges(0, 18, "s2 replay");

    // 3. one-cycle RST pulse just after RN=0011
    #2 rst = 1'b1;
    #1 check_val("s3 async clear", observe(0), 5'b00000);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    push_seq(36, 2, 8, 4);
    run_edges(0, 36, "s3 replay");

    // 4. SWRST held for 3 edges in RUN
    swrst = 1'b1;
    push_const(3, 5'b00000);
    run_edges(0, 3, "s4 swrst held");
    swrst = 1'b0;
    push_seq(34, 0, 8, 4);
    run_edges(0, 34, "s4 after swrst");

    // 6. RST and SWRST together; RST released while SWRST still high
    #2 begin
      rst = 1'b1;
      swrst = 1'b1;
    end
    #1 check_val("s6 async clear", observe(0), 5'b00000);
    @(negedge clk) rst = 1'b0;
    push_const(5, 5'b00000);
    run_edges(0, 5, "s6 swrst held");
    swrst = 1'b0;
    push_seq(34, 0, 8, 4);
    run_edges(0, 34, "s6 after swrst");

    // 5. GAP=1 instance, and an N_OUT=1 / SYNC_STAGES=3 instance
    @(negedge clk) rst_b = 1'b0;
    push_seq(8, 2, 1, 4);
    run_edges(1, 8, "s5 gap1");
    #2 rst_b = 1'b1;
    #1 check_val("nout1 clear", observe(2), 5'b00000);
    @(negedge clk) rst_b = 1'b0;
    push_seq(8, 3, 3, 1);
    run_edges(2, 8, "nout1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
